// File: rtl/hex_display_bank_if.sv
// hex_display_bank_if: host-to-display bundle of value, controls and segment outputs
interface hex_display_bank_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink_en;
    logic                dash;
    logic [7*DIGITS-1:0] out;
    modport master (output value, load, blank_lz, blink_en, dash, input out);
    modport slave (input value, load, blank_lz, blink_en, dash, output out);
endinterface

// File: rtl/hex_display_bank.sv
// hex_display_bank: registered multi-digit active-low hex 7-segment driver with blink, dash and zero blanking
module hex_display_bank #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000
) (
    input logic               CLK,
    input logic               RESETN,
    hex_display_bank_if.slave bus
);
    localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);
    localparam logic [6:0] BLANK_G = 7'b1111111;
    localparam logic [6:0] DASH_G  = 7'b0111111;
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [4*DIGITS-1:0] hold_q, hold_d;
    logic                loaded_q, loaded_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [7*DIGITS-1:0] out_q, out_d;
    logic [DIGITS-1:0]   sup;

    // digit i is a leading zero when it and every digit above it hold 0; digit 0 always shows
    assign sup[0] = 1'b0;
    for (genvar i = 1; i < DIGITS; i++) begin : g_lz
        assign sup[i] = bus.blank_lz && (hold_q[4*DIGITS-1:4*i] == '0);
    end

    // load capture restarts the blink so a fresh value is shown visible first
    always_comb begin
        hold_d   = bus.load ? bus.value : hold_q;
        loaded_d = bus.load | loaded_q;
        cnt_d    = (bus.load || cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        phase_d  = bus.load ? 1'b1 : (cnt_q == CNT_MAX) ? ~phase_q : phase_q;
    end

    // per-digit glyph selection from the current registered state
    always_comb begin
        out_d = '0;
        for (int k = 0; k < DIGITS; k++) begin
            out_d[7*k +: 7] = !loaded_q                      ? BLANK_G :
                              bus.dash                       ? DASH_G  :
                              (bus.blink_en[k] && !phase_q)  ? BLANK_G :
                              sup[k]                         ? BLANK_G :
                                                               GLYPH[hold_q[4*k +: 4]];
        end
    end

    // state and segment registers; reset blanks the display until the next load
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            hold_q   <= '0;
            loaded_q <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            out_q    <= {DIGITS{BLANK_G}};
        end else begin
            hold_q   <= hold_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
        end
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_hex_display_bank.sv
// tb_hex_display_bank: directed checks of the hex display bank for 4, 1 and 8 digits
module tb_hex_display_bank;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    localparam logic [6:0] GL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;
    localparam logic [6:0] Z0 = 7'b1000000;

    hex_display_bank_if #(.DIGITS(4)) ia ();
    hex_display_bank_if #(.DIGITS(1)) ib ();
    hex_display_bank_if #(.DIGITS(8)) ic ();

    hex_display_bank #(.DIGITS(4), .BLINK_DIV(4)) dut_a (.CLK(clk), .RESETN(rstn), .bus(ia.slave));
    hex_display_bank #(.DIGITS(1), .BLINK_DIV(4)) dut_b (.CLK(clk), .RESETN(rstn), .bus(ib.slave));
    hex_display_bank #(.DIGITS(8), .BLINK_DIV(4)) dut_c (.CLK(clk), .RESETN(rstn), .bus(ic.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [55:0] exp_c;
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        ia.value = '0; ia.load = 0; ia.blank_lz = 0; ia.blink_en = '0; ia.dash = 0;
        ib.value = '0; ib.load = 0; ib.blank_lz = 0; ib.blink_en = '0; ib.dash = 0;
        ic.value = '0; ic.load = 0; ic.blank_lz = 0; ic.blink_en = '0; ic.dash = 0;
        repeat (3) step();
        check("reset_blank", 56'(ia.out), 56'(28'hFFFFFFF));
        rstn = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            check("idle_blank", 56'(ia.out), 56'(28'hFFFFFFF));
        end
        ia.value = 16'h12AF; ia.load = 1;
        step();
        ia.load = 0;
        check("load_latency", 56'(ia.out), 56'(28'hFFFFFFF));
        step();
        check("load_12af", 56'(ia.out), 56'({7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}));
        ia.blank_lz = 1; ia.value = 16'h0030; ia.load = 1;
        step();
        ia.load = 0;
        step();
        check("lz_0030", 56'(ia.out), 56'({BL, BL, 7'b0110000, Z0}));
        ia.value = 16'h0000; ia.load = 1;
        step();
        ia.load = 0;
        step();
        check("lz_0000", 56'(ia.out), 56'({BL, BL, BL, Z0}));
        ia.blank_lz = 0;
        step();
        check("lz_off", 56'(ia.out), 56'({Z0, Z0, Z0, Z0}));
        ia.blink_en = 4'b0001; ia.value = 16'h8888; ia.load = 1;
        step();
        ia.load = 0;
        for (int j = 1; j <= 6; j++) begin
            step();
            check("blink", 56'(ia.out), 56'({21'h0, (j >= 5) ? BL : 7'h00}));
        end
        ia.load = 1;
        step();
        ia.load = 0;
        check("blink_reload_edge", 56'(ia.out), 56'({21'h0, BL}));
        step();
        check("blink_reload_vis", 56'(ia.out), 56'(28'h0));
        ia.blank_lz = 1; ia.blink_en = 4'hF; ia.value = 16'h0001; ia.dash = 1; ia.load = 1;
        step();
        ia.load = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            check("dash_priority", 56'(ia.out), 56'({DA, DA, DA, DA}));
        end
        ia.dash = 0; ia.blink_en = '0; ia.blank_lz = 0;
        ia.value = 16'h1111; ia.load = 1;
        step();
        ia.value = 16'h2222;
        step();
        ia.load = 0;
        check("b2b_first", 56'(ia.out), 56'({4{7'b1111001}}));
        step();
        check("b2b_last", 56'(ia.out), 56'({4{7'b0100100}}));
        step();
        check("b2b_settled", 56'(ia.out), 56'({4{7'b0100100}}));
        ia.value = 16'h5555; ia.load = 1; ia.dash = 1; rstn = 1'b0;
        step();
        check("reset_collide", 56'(ia.out), 56'(28'hFFFFFFF));
        rstn = 1'b1; ia.load = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("dash_unloaded", 56'(ia.out), 56'(28'hFFFFFFF));
        end
        for (int n = 0; n < 16; n++) begin
            ib.value = 4'(n);
            for (int k = 0; k < 8; k++) ic.value[4*k +: 4] = 4'((n + k) % 16);
            ib.load = 1; ic.load = 1;
            step();
            ib.load = 0; ic.load = 0;
            step();
            check("sweep_d1", 56'(ib.out), 56'(GL[n]));
            exp_c = '0;
            for (int k = 0; k < 8; k++) exp_c[7*k +: 7] = GL[(n + k) % 16];
            check("sweep_d8", 56'(ic.out), exp_c);
        end
        ic.blank_lz = 1; ic.value = 32'h00000100; ic.load = 1;
        step();
        ic.load = 0;
        step();
        check("lz_d8", 56'(ic.out), {BL, BL, BL, BL, BL, 7'b1111001, Z0, Z0});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
